// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state encoding and default data width for the timer control slice.
package timer_pkg;

    localparam int TIMER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} timer_irq_state_e;

endpackage

// File: rtl/timer_irq_pending.sv
// timer_irq_pending: pending-interrupt flag with ack handshake and saturating missed-expiry counter.
// The counter is built only when TIMER_IRQ_MISSED_CNT_EN is defined; otherwise missed_o is tied to zero.
module timer_irq_pending
    import timer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             set_i,
    input  logic             ack_i,
    output logic             pending_o,
    output logic [CNT_W-1:0] missed_o
);

    logic pending_q, pending_d;

    // A new expiry wins over a simultaneous acknowledge
    assign pending_d = set_i | (pending_q & ~ack_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pending_q <= 1'b0;
        else          pending_q <= pending_d;
    end

    assign pending_o = pending_q;

`ifdef TIMER_IRQ_MISSED_CNT_EN
    logic [CNT_W-1:0] missed_q, missed_d;

    always_comb begin
        missed_d = ack_i ? '0
                 : (set_i && pending_q && missed_q != '1) ? missed_q + 1'b1
                 : missed_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) missed_q <= '0;
        else          missed_q <= missed_d;
    end

    assign missed_o = missed_q;
`else
    assign missed_o = '0;
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: one-shot/periodic sequencer for simple_timer with latched interrupt and compare-match pulse.
// Optional missed-expiry counter enabled by TIMER_IRQ_MISSED_CNT_EN.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    input  logic [WIDTH-1:0] reload_i,
    input  logic [WIDTH-1:0] cmp_i,
    input  logic             irq_ack_i,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] q_i,
    output logic             timer_load_o,
    output logic [WIDTH-1:0] timer_d_o,
    output logic             timer_en_o,
    output logic             irq_o,
    output logic             cmp_match_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] missed_o
);

    timer_irq_state_e state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             oneshot_q, oneshot_d;
    logic             load_q, load_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             eq, eq_q;
    logic             match_q, match_d;
    logic             capture;
    logic             tick_run;

    assign capture  = start_i & ~stop_i;
    assign tick_run = tick_i & (state_q == RUN);

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            reload_q  <= '0;
            oneshot_q <= 1'b0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            eq_q      <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            reload_q  <= reload_d;
            oneshot_q <= oneshot_d;
            load_q    <= load_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            eq_q      <= eq;
            match_q   <= match_d;
        end
    end

    // Stop beats start; start restarts from any state
    always_comb begin
        state_d = stop_i ? IDLE
                : start_i ? LOAD
                : (state_q == LOAD) ? RUN
                : (state_q == RUN && tick_i) ? (oneshot_q ? IDLE : LOAD)
                : state_q;
        reload_d  = capture ? reload_i  : reload_q;
        oneshot_d = capture ? oneshot_i : oneshot_q;
    end

    // Outputs are decoded from the next state so they line up with state_q
    always_comb begin
        load_d  = (state_d == LOAD);
        en_d    = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        eq      = (state_q == RUN) && (q_i == cmp_i);
        match_d = eq & ~eq_q;
    end

    timer_irq_pending #(.CNT_W(CNT_W)) u_pending (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .set_i     (tick_run),
        .ack_i     (irq_ack_i),
        .pending_o (irq_o),
        .missed_o  (missed_o)
    );

    assign timer_load_o = load_q;
    assign timer_d_o    = reload_q;
    assign timer_en_o   = en_q;
    assign cmp_match_o  = match_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed plus randomized checks of timer_irq_ctrl against a behavioural model.
// The bench plays the role of simple_timer, driving tick_i/q_i directly so expiries land on chosen cycles.
module tb_timer_irq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXM  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             start_i, stop_i, oneshot_i, irq_ack_i, tick_i;
    logic [WIDTH-1:0] reload_i, cmp_i, q_i;
    logic             timer_load_o, timer_en_o, irq_o, cmp_match_o, busy_o;
    logic [WIDTH-1:0] timer_d_o;
    logic [CNT_W-1:0] missed_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 loading, 2 running
    int m_phase, m_missed, m_reload;
    bit m_oneshot, m_pend, m_eq_prev, m_match;

    always #5 clk_i = ~clk_i;

    timer_irq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .oneshot_i    (oneshot_i),
        .reload_i     (reload_i),
        .cmp_i        (cmp_i),
        .irq_ack_i    (irq_ack_i),
        .tick_i       (tick_i),
        .q_i          (q_i),
        .timer_load_o (timer_load_o),
        .timer_d_o    (timer_d_o),
        .timer_en_o   (timer_en_o),
        .irq_o        (irq_o),
        .cmp_match_o  (cmp_match_o),
        .busy_o       (busy_o),
        .missed_o     (missed_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_missed = 0; m_reload = 0;
        m_oneshot = 0; m_pend = 0; m_eq_prev = 0; m_match = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".load"},  timer_load_o, m_phase == 1);
        check({tag, ".en"},    timer_en_o,   m_phase == 2);
        check({tag, ".busy"},  busy_o,       m_phase != 0);
        check({tag, ".d"},     timer_d_o,    m_reload);
        check({tag, ".irq"},   irq_o,        m_pend);
        check({tag, ".match"}, cmp_match_o,  m_match);
`ifdef TIMER_IRQ_MISSED_CNT_EN
        check({tag, ".missed"}, missed_o, m_missed);
`else
        check({tag, ".missed"}, missed_o, 0);
`endif
    endtask

    // Apply one cycle of inputs, advance the model by the spec's rules, then compare
    task automatic run(input string tag, input bit st, input bit sp, input bit os,
                       input int rl, input int cm, input bit ak, input bit tk, input int qv);
        bit running, fired, eq;
        start_i = st; stop_i = sp; oneshot_i = os; reload_i = rl[7:0];
        cmp_i = cm[7:0]; irq_ack_i = ak; tick_i = tk; q_i = qv[7:0];
        @(posedge clk_i);
        running   = (m_phase == 2);
        fired     = tk && running;
        eq        = running && (qv == cm);
        m_match   = eq && !m_eq_prev;
        m_eq_prev = eq;
        if (ak) m_missed = 0;
        else if (fired && m_pend) m_missed = (m_missed < MAXM) ? m_missed + 1 : MAXM;
        m_pend = fired || (m_pend && !ak);
        if (sp) m_phase = 0;
        else if (st) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
        else if (fired) m_phase = m_oneshot ? 0 : 1;
        if (st && !sp) begin
            m_reload  = rl;
            m_oneshot = os;
        end
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag, input int qv);
        run(tag, 0, 0, 0, 0, 8'hff, 0, 0, qv);
    endtask

    initial begin
        int pulses, fired;
        rst_n_i = 1'b0;
        start_i = 0; stop_i = 0; oneshot_i = 0; irq_ack_i = 0; tick_i = 0;
        reload_i = '0; cmp_i = '0; q_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.load", timer_load_o, 0);
        check("reset.en", timer_en_o, 0);
        check("reset.busy", busy_o, 0);
        check("reset.irq", irq_o, 0);
        check("reset.d", timer_d_o, 0);
        check("reset.match", cmp_match_o, 0);
        check("reset.missed", missed_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // One-shot
        run("os.start", 1, 0, 1, 8'h05, 8'hff, 0, 0, 0);
        check("os.load_pulse", timer_load_o, 1);
        check("os.load_d", timer_d_o, 8'h05);
        idle("os.run", 5);
        check("os.en", timer_en_o, 1);
        idle("os.run2", 4);
        run("os.tick", 0, 0, 0, 0, 8'hff, 0, 1, 0);
        check("os.irq", irq_o, 1);
        check("os.en_drop", timer_en_o, 0);
        check("os.busy_drop", busy_o, 0);
        run("os.ack", 0, 0, 0, 0, 8'hff, 1, 0, 0);
        check("os.ack_clear", irq_o, 0);

        // Periodic
        run("per.start", 1, 0, 0, 8'h05, 8'hff, 0, 0, 0);
        idle("per.run", 5);
        for (int i = 0; i < 3; i++) begin
            run("per.tick", 0, 0, 0, 0, 8'hff, 0, 1, 0);
            check("per.reload_pulse", timer_load_o, 1);
            check("per.reload_d", timer_d_o, 8'h05);
            idle("per.resume", 5);
            check("per.en_resume", timer_en_o, 1);
        end
        run("per.ack", 0, 0, 0, 0, 8'hff, 1, 0, 4);
        check("per.ack_clear", irq_o, 0);

        // Missed counter: tick on every running cycle
        fired = 0;
        for (int i = 0; i < 80 && fired < 20; i++) begin
            if (m_phase == 2) fired++;
            run("miss.tick", 0, 0, 0, 0, 8'hff, 0, m_phase == 2, 0);
`ifdef TIMER_IRQ_MISSED_CNT_EN
            if (fired == 3 && m_phase == 1) check("miss.three", missed_o, 2);
`endif
        end
`ifdef TIMER_IRQ_MISSED_CNT_EN
        check("miss.saturate", missed_o, 15);
`else
        check("miss.disabled", missed_o, 0);
`endif
        idle("miss.run", 5);
        run("miss.tick_ack", 0, 0, 0, 0, 8'hff, 1, 1, 0);
        check("miss.tick_ack_irq", irq_o, 1);
        check("miss.tick_ack_cnt", missed_o, 0);

        // Control priority
        idle("ctl.run", 5);
        idle("ctl.run2", 5);
        run("ctl.stop", 0, 1, 0, 0, 8'hff, 0, 0, 5);
        check("ctl.stop_en", timer_en_o, 0);
        check("ctl.stop_irq", irq_o, 1);
        run("ctl.start_stop", 1, 1, 0, 8'h33, 8'hff, 0, 0, 0);
        check("ctl.start_stop_busy", busy_o, 0);
        run("ctl.start", 1, 0, 0, 8'h05, 8'hff, 0, 0, 0);
        idle("ctl.run3", 5);
        run("ctl.restart", 1, 0, 0, 8'h09, 8'hff, 0, 0, 5);
        check("ctl.restart_load", timer_load_o, 1);
        check("ctl.restart_d", timer_d_o, 8'h09);

        // Compare: q==cmp for four running cycles gives one pulse
        pulses = 0;
        run("cmp.pre", 0, 0, 0, 0, 8'h03, 0, 0, 7);
        for (int i = 0; i < 4; i++) begin
            run("cmp.hold", 0, 0, 0, 0, 8'h03, 0, 0, 3);
            pulses += cmp_match_o;
        end
        run("cmp.post", 0, 0, 0, 0, 8'h03, 0, 0, 2);
        pulses += cmp_match_o;
        check("cmp.single_pulse", pulses, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            run("rnd", $urandom_range(15) == 0, $urandom_range(31) == 0, $urandom_range(1),
                $urandom_range(255), $urandom_range(3), $urandom_range(7) == 0,
                $urandom_range(3) == 0, $urandom_range(3));
        end

        // Asynchronous reset in the middle of a sequence
        run("rst.start", 1, 0, 0, 8'h44, 8'hff, 0, 0, 0);
        idle("rst.run", 1);
        run("rst.tick", 0, 0, 0, 0, 8'hff, 0, 1, 0);
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check_model("rst.async");
        @(posedge clk_i);
        #1;
        check_model("rst.held");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle("rst.after", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
